// File: rtl/mem_access_unit.sv
// Memory access stage: issues one aligned load/store per instruction over a req/ack bus,
// formats byte/half lanes, and registers the write-back and Hi/Lo results.
module mem_access_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  dataTypeIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        HiLoWriteIn,
  input  logic [4:0]  rdRegIn,
  input  logic [63:0] MultResultIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic [31:0] WBData,
  output logic [4:0]  WBRd,
  output logic        WBRegWrite,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        mis_q, mis_d;

  logic        is_half, is_byte, is_word;
  logic        access, is_load, misalign, aligned_access;
  logic [3:0]  be_sel;
  logic [31:0] wdata_sel;
  logic [31:0] lane_shift;
  logic [31:0] load_result;
  logic        retire;

  // Store wins when both read and write are requested.
  always_comb begin
    is_half        = (dataTypeIn == 2'b01);
    is_byte        = (dataTypeIn == 2'b10);
    is_word        = ~(is_half | is_byte);
    access         = MemReadIn | MemWriteIn;
    is_load        = MemReadIn & ~MemWriteIn;
    misalign       = access & ((is_word & (|ALUResultIn[1:0])) | (is_half & ALUResultIn[0]));
    aligned_access = access & ~misalign;
  end

  always_comb begin
    be_sel    = 4'b1111;
    wdata_sel = MemDataIn;
    if (is_half) begin
      be_sel    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
      wdata_sel = {2{MemDataIn[15:0]}};
    end else if (is_byte) begin
      be_sel    = 4'b0001 << ALUResultIn[1:0];
      wdata_sel = {4{MemDataIn[7:0]}};
    end
  end

  // Half accesses are aligned here, so the shift is 0 or 16.
  always_comb begin
    lane_shift = rdata_q >> {ALUResultIn[1:0], 3'b000};
    if (is_byte) begin
      load_result = {{24{lane_shift[7]}}, lane_shift[7:0]};
    end else if (is_half) begin
      load_result = {{16{lane_shift[15]}}, lane_shift[15:0]};
    end else begin
      load_result = rdata_q;
    end
  end

  // Upstream is held through RESP, so the inputs still describe the in-flight instruction.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mis_d       = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aligned_access) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MemWriteIn;
          mem_addr_d  = {ALUResultIn[31:2], 2'b00};
          mem_wdata_d = wdata_sel;
          mem_be_d    = be_sel;
          state_d     = StWait;
        end else begin
          retire = 1'b1;
          mis_d  = misalign;
        end
      end
      StWait: begin
        if (MemAck) begin
          mem_req_d = 1'b0;
          rdata_d   = MemRData;
          state_d   = StResp;
        end
      end
      StResp: begin
        retire  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (retire) begin
      wb_data_d = ((state_q == StResp) && MemToRegIn && is_load) ? load_result : ALUResultIn;
      wb_rd_d   = rdRegIn;
      wb_rw_d   = RegWriteIn & ~mis_d;
      if (HiLoWriteIn) begin
        hi_d = MultResultIn[63:32];
        lo_d = MultResultIn[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      rdata_q     <= 32'h0;
      wb_data_q   <= 32'h0;
      wb_rd_q     <= 5'h0;
      wb_rw_q     <= 1'b0;
      hi_q        <= 32'h0;
      lo_q        <= 32'h0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mis_q       <= mis_d;
    end
  end

  assign Stall       = ((state_q == StIdle) && aligned_access) || (state_q == StWait);
  assign MemReq      = mem_req_q;
  assign MemWe       = mem_we_q;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign MemByteEn   = mem_be_q;
  assign WBData      = wb_data_q;
  assign WBRd        = wb_rd_q;
  assign WBRegWrite  = wb_rw_q;
  assign HiOut       = hi_q;
  assign LoOut       = lo_q;
  assign MisalignErr = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expectations from a reference model,
// a bus responder and a write-back monitor pop and compare them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResultIn, MemDataIn;
  logic        MemReadIn, MemWriteIn;
  logic [1:0]  dataTypeIn;
  logic        RegWriteIn, MemToRegIn, HiLoWriteIn;
  logic [4:0]  rdRegIn;
  logic [63:0] MultResultIn;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemByteEn;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Stall;
  logic [31:0] WBData;
  logic [4:0]  WBRd;
  logic        WBRegWrite;
  logic [31:0] HiOut, LoOut;
  logic        MisalignErr;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .Reset        (Reset),
    .ALUResultIn  (ALUResultIn),
    .MemDataIn    (MemDataIn),
    .MemReadIn    (MemReadIn),
    .MemWriteIn   (MemWriteIn),
    .dataTypeIn   (dataTypeIn),
    .RegWriteIn   (RegWriteIn),
    .MemToRegIn   (MemToRegIn),
    .HiLoWriteIn  (HiLoWriteIn),
    .rdRegIn      (rdRegIn),
    .MultResultIn (MultResultIn),
    .MemReq       (MemReq),
    .MemWe        (MemWe),
    .MemAddr      (MemAddr),
    .MemWData     (MemWData),
    .MemByteEn    (MemByteEn),
    .MemAck       (MemAck),
    .MemRData     (MemRData),
    .Stall        (Stall),
    .WBData       (WBData),
    .WBRd         (WBRd),
    .WBRegWrite   (WBRegWrite),
    .HiOut        (HiOut),
    .LoOut        (LoOut),
    .MisalignErr  (MisalignErr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_exp_t;

  mem_exp_t    mem_q[$];
  wb_exp_t     wb_q[$];
  int          mis_pending = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;
  logic        resp_en = 1'b1;
  logic        man_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write-back / misalign monitor
  wb_exp_t mon_e;
  always @(negedge clk) begin
    if (WBRegWrite === 1'b1) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected_pulse", 64'(WBRd), 64'h0);
        if (WBRd == 5'h0) chk("wb_unexpected_pulse", 64'h1, 64'h0);
      end else begin
        mon_e = wb_q.pop_front();
        chk("wb_data", 64'(WBData), 64'(mon_e.data));
        chk("wb_rd", 64'(WBRd), 64'(mon_e.rd));
        chk("wb_hi", 64'(HiOut), 64'(mon_e.hi));
        chk("wb_lo", 64'(LoOut), 64'(mon_e.lo));
      end
    end
    if (MisalignErr === 1'b1) begin
      chk("misalign_expected", 64'(mis_pending > 0), 64'h1);
      if (mis_pending > 0) mis_pending--;
    end
  end

  // Memory responder: checks each request and acks after the chosen number of WAIT cycles
  mem_exp_t    cur;
  int          wcnt = 0;
  logic [31:0] snap_addr, snap_wd;
  logic        snap_we;
  logic [3:0]  snap_be;
  logic [31:0] lane_mask;
  initial begin
    MemAck   = 1'b0;
    MemRData = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        MemAck   = man_ack;
        MemRData = 32'h0;
        wcnt     = 0;
      end else if (MemReq) begin
        if (wcnt == 0) begin
          if (mem_q.size() == 0) begin
            chk("mem_req_unexpected", 64'h1, 64'h0);
            cur.delay = 1;
            cur.rdata = 32'h0;
          end else begin
            cur = mem_q.pop_front();
            chk("mem_addr", 64'(MemAddr), 64'(cur.addr));
            chk("mem_we", 64'(MemWe), 64'(cur.we));
            chk("mem_byte_en", 64'(MemByteEn), 64'(cur.be));
            if (cur.we) begin
              lane_mask = {{8{cur.be[3]}}, {8{cur.be[2]}}, {8{cur.be[1]}}, {8{cur.be[0]}}};
              chk("mem_wdata", 64'(MemWData & lane_mask), 64'(cur.wdata & lane_mask));
            end
          end
          snap_addr = MemAddr;
          snap_we   = MemWe;
          snap_be   = MemByteEn;
          snap_wd   = MemWData;
        end else begin
          chk("mem_hold_addr", 64'(MemAddr), 64'(snap_addr));
          chk("mem_hold_ctl", 64'({MemWe, MemByteEn}), 64'({snap_we, snap_be}));
          chk("mem_hold_wdata", 64'(MemWData), 64'(snap_wd));
        end
        wcnt++;
        if (wcnt == cur.delay) begin
          MemAck   = 1'b1;
          MemRData = cur.rdata;
        end else begin
          MemAck   = 1'b0;
          MemRData = $urandom;
        end
      end else begin
        wcnt     = 0;
        MemAck   = 1'($urandom_range(0, 1));
        MemRData = $urandom;
      end
    end
  end

  task automatic set_idle();
    ALUResultIn  = 32'h0;
    MemDataIn    = 32'h0;
    MemReadIn    = 1'b0;
    MemWriteIn   = 1'b0;
    dataTypeIn   = 2'b00;
    RegWriteIn   = 1'b0;
    MemToRegIn   = 1'b0;
    HiLoWriteIn  = 1'b0;
    rdRegIn      = 5'h0;
    MultResultIn = 64'h0;
  endtask

  // Reference model + driver for one instruction; returns after it is consumed (Stall low edge).
  task automatic run_instr(input logic rd_en, input logic wr_en, input logic [1:0] dt,
                           input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                           input logic m2r, input logic hl, input logic [4:0] rd,
                           input logic [63:0] mult, input int d, input logic [31:0] rdata);
    logic        is_mem, is_load, mis, st, done;
    int          sz, off, stalls, exp_stalls, cyc;
    logic [3:0]  be;
    logic [31:0] wexp, sh, lres, wbd;
    mem_exp_t    m;
    wb_exp_t     w;
    is_mem  = rd_en | wr_en;
    is_load = rd_en & ~wr_en;
    sz      = (dt == 2'b01) ? 2 : ((dt == 2'b10) ? 1 : 4);
    mis     = is_mem && ((sz == 4 && addr[1:0] != 2'b00) || (sz == 2 && addr[0]));
    if (sz == 4) begin
      be = 4'b1111; wexp = wd;
    end else if (sz == 2) begin
      be = addr[1] ? 4'b1100 : 4'b0011; wexp = {2{wd[15:0]}};
    end else begin
      be = 4'b0001 << addr[1:0]; wexp = {4{wd[7:0]}};
    end
    off = int'(addr[1:0]);
    sh  = rdata >> (8 * off);
    if (sz == 1) lres = {{24{sh[7]}}, sh[7:0]};
    else if (sz == 2) lres = {{16{sh[15]}}, sh[15:0]};
    else lres = rdata;
    wbd = (is_load && m2r && !mis) ? lres : addr;
    if (hl) begin
      model_hi = mult[63:32];
      model_lo = mult[31:0];
    end
    exp_stalls = (is_mem && !mis) ? 1 + d : 0;
    if (is_mem && !mis) begin
      m.addr = {addr[31:2], 2'b00}; m.we = wr_en; m.be = be; m.wdata = wexp;
      m.delay = d; m.rdata = rdata;
      mem_q.push_back(m);
    end
    if (rw && !mis) begin
      w.data = wbd; w.rd = rd; w.hi = model_hi; w.lo = model_lo;
      wb_q.push_back(w);
    end
    if (mis) mis_pending++;
    ALUResultIn = addr; MemDataIn = wd; MemReadIn = rd_en; MemWriteIn = wr_en;
    dataTypeIn = dt; RegWriteIn = rw; MemToRegIn = m2r; HiLoWriteIn = hl;
    rdRegIn = rd; MultResultIn = mult;
    stalls = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      st = Stall;
      if (st) stalls++;
      @(posedge clk);
      #1;
      cyc++;
      if (!st) done = 1'b1;
    end
    chk("instr_timeout", 64'(done), 64'h1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    chk("retire_regwrite", 64'(WBRegWrite), 64'(rw && !mis));
    chk("retire_misalign", 64'(MisalignErr), 64'(mis));
    chk("retire_hilo", {HiOut, LoOut}, {model_hi, model_lo});
  endtask

  initial begin
    Reset = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem", 64'({MemReq, MemWe, MemByteEn, MemAddr}), 64'h0);
    chk("reset_wdata", 64'(MemWData), 64'h0);
    chk("reset_wb", 64'({WBData, WBRd, WBRegWrite, MisalignErr}), 64'h0);
    chk("reset_hilo", {HiOut, LoOut}, 64'h0);
    chk("reset_stall", 64'(Stall), 64'h0);
    Reset = 1'b0;

    // Directed scenarios
    run_instr(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 5'd5, 64'h0, 3, 32'hDEADBEEF);
    run_instr(1'b1, 1'b0, 2'b10, 32'h103, 32'h0, 1'b1, 1'b1, 1'b0, 5'd6, 64'h0, 1, 32'h80112233);
    run_instr(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 1'b1, 1'b1, 1'b0, 5'd7, 64'h0, 2, 32'h80112233);
    run_instr(1'b0, 1'b1, 2'b10, 32'h101, 32'hAB, 1'b0, 1'b0, 1'b0, 5'd8, 64'h0, 1, 32'h0);
    run_instr(1'b1, 1'b0, 2'b00, 32'h102, 32'h0, 1'b1, 1'b1, 1'b0, 5'd9, 64'h0, 1, 32'h0);
    run_instr(1'b0, 1'b0, 2'b00, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 64'h1_FFFFFFFE, 1,
              32'h0);
    run_instr(1'b1, 1'b1, 2'b11, 32'h200, 32'h5555AAAA, 1'b1, 1'b1, 1'b0, 5'd10, 64'h0, 2,
              32'h12345678);
    run_instr(1'b0, 1'b0, 2'b00, 32'hCAFE0001, 32'h0, 1'b1, 1'b0, 1'b0, 5'd11, 64'h0, 1, 32'h0);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      run_instr(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom),
                1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
                int'($urandom_range(1, 4)), $urandom);
    end
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("drain_wb_queue", 64'(wb_q.size()), 64'h0);
    chk("drain_mem_queue", 64'(mem_q.size()), 64'h0);
    chk("drain_misalign", 64'(mis_pending), 64'h0);

    // Reset in the second WAIT cycle, late ack afterwards
    resp_en = 1'b0;
    man_ack = 1'b0;
    ALUResultIn = 32'h300; MemReadIn = 1'b1; RegWriteIn = 1'b1; MemToRegIn = 1'b1;
    rdRegIn = 5'd12;
    @(posedge clk);
    #1;
    chk("abort_req_issued", 64'({MemReq, Stall}), 64'h3);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    man_ack = 1'b1;
    set_idle();
    chk("abort_req_dropped", 64'(MemReq), 64'h0);
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    chk("abort_late_ack", 64'({MemReq, WBRegWrite, Stall}), 64'h0);
    chk("abort_cleared", 64'({WBData, HiOut}), 64'h0);
    @(posedge clk);
    #1;
    chk("abort_no_retire", 64'({MemReq, WBRegWrite}), 64'h0);
    model_hi = 32'h0;
    model_lo = 32'h0;
    resp_en  = 1'b1;
    run_instr(1'b0, 1'b0, 2'b00, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 5'd13, 64'h0, 1, 32'h0);
    run_instr(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 1'b1, 1'b1, 1'b0, 5'd14, 64'h0, 1, 32'h00007FFF);
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("final_wb_queue", 64'(wb_q.size()), 64'h0);
    chk("final_mem_queue", 64'(mem_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ALUResultIn  in  32  byte address / non-memory result (from EX/MEM).
REQ-004 SHALL have ports: MemDataIn  in  32  store data; MemReadIn, MemWriteIn  in  1 each; dataTypeIn  in  2  00 word, 01 half, 10 byte, 11 treated as word.
REQ-005 SHALL have ports: RegWriteIn, MemToRegIn, HiLoWriteIn  in  1 each; rdRegIn  in  5; MultResultIn  in  64.
REQ-006 SHALL have ports: MemReq  out  1; MemWe  out  1; MemAddr  out  32  word-aligned (bits[1:0]=00); MemWData  out  32; MemByteEn  out  4; MemAck  in  1; MemRData  in  32.
REQ-007 SHALL have ports: Stall  out  1  hold EX/MEM and upstream stages.
REQ-008 SHALL have ports: WBData  out  32; WBRd  out  5; WBRegWrite  out  1; HiOut, LoOut  out  32 each; MisalignErr  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-010 Access request = MemWriteIn | MemReadIn; MemWriteIn has priority, so when both are high the access is a store and produces no load result.
REQ-011 Misaligned = (word & addr[1:0]!=0) | (half & addr[0]=1); a misaligned access SHALL issue no memory request, pulse MisalignErr for one cycle, and retire with WBRegWrite=0.
REQ-012 IDLE + aligned access: next edge SHALL register MemReq=1, MemWe, MemAddr={addr[31:2],2'b00}, MemByteEn, MemWData, then go to WAIT.
REQ-013 Stall SHALL be combinational: high in IDLE with an aligned access pending, high in WAIT, low in RESP.
REQ-014 WAIT: MemReq and all Mem* outputs SHALL remain stable until MemAck=1; an ack in the first WAIT cycle SHALL be accepted.
REQ-015 On the edge where WAIT sees MemAck, the block SHALL drop MemReq, capture MemRData, and go to RESP.
REQ-016 RESP: the block SHALL retire the access for one cycle and return to IDLE on the next edge; MemAck in IDLE or RESP SHALL be ignored.
REQ-017 Byte lanes are little-endian: byte at addr[1:0]=k uses MemRData/MemWData[8k+7:8k]; half uses lanes {addr[1],0}..+1.
REQ-018 Store enables: word 1111, half 0011 or 1100, byte one-hot at lane k; store data SHALL be replicated into the selected lane(s).
REQ-019 Load result: byte and half SHALL be sign-extended to 32 bits; word SHALL pass through unchanged.
REQ-020 Retire edge is the IDLE edge of a non-memory or misaligned instruction, or the RESP->IDLE edge; WBData/WBRd/WBRegWrite SHALL be registered on that edge.
REQ-021 WBData SHALL be the load result if MemToRegIn & load, else ALUResultIn; WBRegWrite=RegWriteIn, except 0 on a misaligned access.
REQ-022 Non-memory instruction latency SHALL be 1 cycle; memory instruction latency SHALL be 2 cycles after MemAck.
REQ-023 HiLoWriteIn SHALL update HiOut=MultResultIn[63:32] and LoOut=MultResultIn[31:0] only on the retire edge, exactly once per instruction.
REQ-024 In non-retire cycles WBRegWrite SHALL be 0; other WB outputs SHALL hold.

Reset
REQ-025 Reset SHALL force state IDLE and clear MemReq, MemWe, MemAddr, MemWData, MemByteEn, WBData, WBRd, WBRegWrite, HiOut, LoOut, and MisalignErr to 0.
REQ-026 Reset in WAIT SHALL abort the access: MemReq=0 the next cycle, and a late MemAck SHALL be ignored without any retire.
REQ-027 Reset SHALL take priority over MemAck and every input on the same edge.

Verification
REQ-028 Load word: addr 0x100, MemAck 3 cycles after MemReq, MemRData 0xDEADBEEF, MemToReg=1, rd=5 -> Stall high 4 cycles, then WBData=0xDEADBEEF, WBRd=5, WBRegWrite=1 for 1 cycle.
REQ-029 Load byte: addr 0x103, MemRData 0x80112233 -> WBData=0xFFFFFF80; load half at addr 0x102 -> WBData=0xFFFF8011.
REQ-030 Store byte: addr 0x101, data 0x000000AB -> MemByteEn=0010, MemWData[15:8]=0xAB, MemWe=1, WBRegWrite=0.
REQ-031 Misaligned load word at 0x102 -> MemReq never asserts, MisalignErr=1 for 1 cycle, Stall=0.
REQ-032 HiLoWriteIn=1, MultResultIn=0x00000001_FFFFFFFE, no memory access -> one cycle later HiOut=1, LoOut=0xFFFFFFFE.
REQ-033 Reset asserted in the second WAIT cycle, MemAck the following cycle -> MemReq=0, no WBRegWrite pulse, state IDLE.
